// File: rtl/ein_rx.sv
// ---------------------------------------------------------------------------
// ein_rx -- receive side of the EIN transition-coded pad link.
//
// Each symbol is a single toggle on one of three asynchronous pads:
//   EMO toggles delimit frames (start / end),
//   EDI toggles carry a 0 bit, ECI toggles carry a 1 bit.
// Bits arrive MSB first. Completed bytes and frame boundaries are handed to
// the bus-side logic. Protocol violations and inactivity abort the frame,
// and the receiver then waits for a quiet line before it accepts a new frame.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   EMO_PAD          async frame-delimiter pad
//   EDI_PAD          async data-0 pad
//   ECI_PAD          async data-1 pad
//   out_data         last completed byte (held until the next one)
//   out_data_valid   1-cycle pulse when out_data is updated
//   out_frame_valid  high from frame start until clean end or abort
//   out_frame_done   1-cycle pulse on a clean end delimiter
//   out_error        1-cycle pulse on protocol error or timeout
//   out_byte_count   bytes in the current/last frame, saturating at 255
// ---------------------------------------------------------------------------
module ein_rx #(
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int TIMEOUT_WIDTH  = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EMO_PAD,
  input  logic       EDI_PAD,
  input  logic       ECI_PAD,
  output logic [7:0] out_data,
  output logic       out_data_valid,
  output logic       out_frame_valid,
  output logic       out_frame_done,
  output logic       out_error,
  output logic [7:0] out_byte_count
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ONE = TIMEOUT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    QUIET = 2'd2
  } state_t;

  // Pad vector: bit 0 = EMO, bit 1 = EDI, bit 2 = ECI.
  logic [2:0] pads;
  assign pads = {ECI_PAD, EDI_PAD, EMO_PAD};

  // -------------------------------------------------------------------------
  // Synchronizer, edge detection and priming
  // -------------------------------------------------------------------------
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] hist_q;
  logic [2:0] edge_q;
  logic [1:0] prime_cnt_q;
  logic       primed;

  // Edges are masked until the history flop holds a real sampled pad level,
  // so pads that are already high when reset releases produce no edge.
  assign primed = (prime_cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      edge_q      <= '0;
      prime_cnt_q <= '0;
    end else begin
      sync1_q <= pads;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      edge_q  <= primed ? (sync2_q ^ hist_q) : 3'b000;
      if (!primed) begin
        prime_cnt_q <= prime_cnt_q + 2'd1;
      end
    end
  end

  logic any_edge;
  logic multi_edge;
  logic emo_edge;
  logic emo_only;
  logic edi_only;
  logic eci_only;

  assign any_edge   = |edge_q;
  assign multi_edge = (edge_q[0] & edge_q[1]) | (edge_q[0] & edge_q[2]) |
                      (edge_q[1] & edge_q[2]);
  assign emo_edge   = edge_q[0];
  assign emo_only   = (edge_q == 3'b001);
  assign edi_only   = (edge_q == 3'b010);
  assign eci_only   = (edge_q == 3'b100);

  // -------------------------------------------------------------------------
  // Decoder state
  // -------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_data_valid_q, out_data_valid_d;
  logic                     out_frame_valid_q, out_frame_valid_d;
  logic                     out_frame_done_q, out_frame_done_d;
  logic                     out_error_q, out_error_d;
  logic [7:0]               out_byte_count_q, out_byte_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      bit_cnt_q         <= '0;
      shift_q           <= '0;
      timer_q           <= '0;
      out_data_q        <= '0;
      out_data_valid_q  <= 1'b0;
      out_frame_valid_q <= 1'b0;
      out_frame_done_q  <= 1'b0;
      out_error_q       <= 1'b0;
      out_byte_count_q  <= '0;
    end else begin
      state_q           <= state_d;
      bit_cnt_q         <= bit_cnt_d;
      shift_q           <= shift_d;
      timer_q           <= timer_d;
      out_data_q        <= out_data_d;
      out_data_valid_q  <= out_data_valid_d;
      out_frame_valid_q <= out_frame_valid_d;
      out_frame_done_q  <= out_frame_done_d;
      out_error_q       <= out_error_d;
      out_byte_count_q  <= out_byte_count_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    bit_cnt_d         = bit_cnt_q;
    shift_d           = shift_q;
    timer_d           = timer_q;
    out_data_d        = out_data_q;
    out_data_valid_d  = 1'b0;
    out_frame_valid_d = out_frame_valid_q;
    out_frame_done_d  = 1'b0;
    out_error_d       = 1'b0;
    out_byte_count_d  = out_byte_count_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (emo_edge && multi_edge) begin
          out_error_d       = 1'b1;
          out_frame_valid_d = 1'b0;
          state_d           = QUIET;
        end else if (emo_only) begin
          state_d           = RECV;
          out_frame_valid_d = 1'b1;
          bit_cnt_d         = '0;
          shift_d           = '0;
          out_byte_count_d  = '0;
        end
      end

      RECV: begin
        // Error checks come first so an abort always beats byte completion;
        // the partial byte is simply dropped and the byte count is held.
        if (multi_edge || (emo_only && (bit_cnt_q != 3'd0)) ||
            (!any_edge && (timer_q == TIMER_MAX))) begin
          out_error_d       = 1'b1;
          out_frame_valid_d = 1'b0;
          timer_d           = '0;
          state_d           = QUIET;
        end else if (emo_only) begin
          out_frame_done_d  = 1'b1;
          out_frame_valid_d = 1'b0;
          timer_d           = '0;
          state_d           = IDLE;
        end else if (edi_only || eci_only) begin
          shift_d   = {shift_q[6:0], eci_only};
          bit_cnt_d = bit_cnt_q + 3'd1;
          timer_d   = '0;
          if (bit_cnt_q == 3'd7) begin
            out_data_d       = {shift_q[6:0], eci_only};
            out_data_valid_d = 1'b1;
            if (out_byte_count_q != 8'hFF) begin
              out_byte_count_d = out_byte_count_q + 8'd1;
            end
          end
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      QUIET: begin
        // The line must stay silent for a full timeout period; any edge,
        // including an EMO, only restarts the wait.
        if (any_edge) begin
          timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        timer_d           = '0;
        out_frame_valid_d = 1'b0;
        state_d           = IDLE;
      end
    endcase
  end

  assign out_data        = out_data_q;
  assign out_data_valid  = out_data_valid_q;
  assign out_frame_valid = out_frame_valid_q;
  assign out_frame_done  = out_frame_done_q;
  assign out_error       = out_error_q;
  assign out_byte_count  = out_byte_count_q;

endmodule

// File: doc/ein_rx.md
Name: ein_rx

Overview:
- Receive-side counterpart of the EIN pad transmitter.
- Samples the three asynchronous transition-coded pads EMO/EDI/ECI and decodes one toggle per symbol back into bytes.
- Presents bytes and frame boundaries to the bus-side logic, which packetizes and forwards them.
- Decoding includes protocol error detection and an inactivity timeout.

Parameters:
TIMEOUT_CYCLES, 16000, clk cycles without any pad edge while in RECV before abort; also the quiet period required to leave QUIET (4x nominal 4000-cycle symbol)
TIMEOUT_WIDTH, 14, width of the inactivity timer; must hold TIMEOUT_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
EMO_PAD  input  1  async; each toggle is a frame delimiter (start/end)
EDI_PAD  input  1  async; each toggle is data bit 0
ECI_PAD  input  1  async; each toggle is data bit 1
out_data  output  8  last completed byte, MSB received first
out_data_valid  output  1  1-cycle pulse, out_data newly valid
out_frame_valid  output  1  high from frame-start delimiter until frame end or abort
out_frame_done  output  1  1-cycle pulse on clean end delimiter
out_error  output  1  1-cycle pulse on protocol error or timeout
out_byte_count  output  8  bytes received in current/last frame, saturates at 255

Behaviour:
- Reset: synchronous, active-high, on clk. All outputs 0. Synchronizer and edge registers 0. State IDLE. `primed` flag 0.
- Synchronizer: 2 flops per pad, then 1 history flop. An edge is sync XOR history.
- Edge latency: a pad change produces an edge 3 clk cycles later.
- Priming: edge detection is masked until `primed` is set. `primed` is set 3 cycles after reset deasserts. No edge is reported for pads already high at reset.
- Multi-edge: more than one of the three pads edging in the same cycle is a multi-edge condition.

States:
- IDLE
  - EMO edge alone -> RECV. Set out_frame_valid=1, clear bit count, shift register, timer and out_byte_count.
  - EDI/ECI edges are ignored.
  - A multi-edge that includes EMO -> error.
- RECV
  - EDI edge alone: shift 0 into the shift register.
  - ECI edge alone: shift 1 into the shift register.
  - Each data edge increments the 3-bit bit count and clears the timer.
  - On the 8th bit, the following cycle: out_data = byte, out_data_valid=1 for one cycle, out_byte_count+1 (saturating), bit count wraps to 0.
  - EMO edge alone with bit count 0 -> IDLE. The next cycle: out_frame_done=1, out_frame_valid=0. Empty frames are legal (count 0).
  - EMO edge with bit count != 0 -> error.
  - Multi-edge -> error.
  - Timer reaching TIMEOUT_CYCLES-1 with no edge -> error.
- Error action: out_error=1 for one cycle, out_frame_valid=0, no out_data_valid for the partial byte, out_byte_count held. Enter QUIET.
- QUIET
  - Timer counts from 0; any edge on any pad restarts it at 0.
  - When the timer reaches TIMEOUT_CYCLES-1 -> IDLE. EMO edges in QUIET do not start a frame.
- Backpressure: none. The consumer must take out_data within one symbol period. out_data holds until the next completed byte.
- Simultaneous events:
  - An error condition takes priority over byte completion in the same cycle.
  - Reset mid-frame overrides everything. No done/error pulse is emitted, and priming is repeated.
- Timer: counts only in RECV and QUIET; held at 0 in IDLE. It never wraps; it stops at TIMEOUT_CYCLES-1.

Test Plan:
- Frame test (TIMEOUT_CYCLES=64): EMO, then toggles ECI,EDI,ECI,EDI,EDI,ECI,EDI,ECI (10 cycles apart), then EMO -> out_data=0xA5 with a single valid pulse 4 cycles after the last ECI pad change; out_frame_done pulse; out_byte_count=1; out_frame_valid high over the frame.
- Two-byte frame: send 0x00 then 0xFF back-to-back -> two valid pulses with 0x00 then 0xFF; out_byte_count=2; no out_error.
- Early end: EMO, 5 data toggles, EMO -> out_error pulse; no out_data_valid. An EMO edge during QUIET is ignored. After 64 quiet cycles, a new 0x3C frame decodes correctly.
- Multi-edge: EDI and ECI toggled in the same clk mid-byte -> out_error; out_frame_valid drops the same cycle the error pulses.
- Timeout: stop after 3 bits -> out_error exactly 64 cycles after the last edge's detection; no pulse at 63.
- Reset behaviour: hold all pads high through reset -> no frame, no error. Reset asserted mid-frame -> all outputs 0; the next full frame decodes normally.
